// File: rtl/scan_pkg.sv
// scan_pkg: state encoding and external row/col counter command codes for the pixel scan sequencer
package scan_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_ROW_SEL,
        S_ROW_RST,
        S_INTEG,
        S_COL_SEL,
        S_SETTLE,
        S_KEY,
        S_WAIT_ADC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [4:0] CNT_CLR  = 5'b10000;
    localparam logic [4:0] CNT_INC  = 5'b01000;
    localparam logic [4:0] CNT_HOLD = 5'b00000;

    localparam logic [11:0] ADC_TIMEOUT_DATA = 12'hFFF;

endpackage

// File: rtl/scan_timer.sv
// scan_timer: 8-bit loadable down-counter that stops at zero
//   clk, rst   clock, async active-high reset
//   en         clock enable; count and load happen only when high
//   load       load load_val this cycle (takes priority over counting)
//   load_val   value loaded
//   zero       count is zero
module scan_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= load ? load_val : (cnt != 8'd0 ? cnt - 8'd1 : cnt);
    end

    assign zero = cnt == 8'd0;

endmodule

// File: rtl/pixel_scan_ctrl.sv
// pixel_scan_ctrl: row/column scan sequencer for the pixel matrix, writes one ADC sample per pixel to RAM
//   clk, rst          clock, async active-high reset
//   en                clock enable; everything frozen when low
//   i_go              scan runs only while high
//   i_adc_valid/data  1-cycle sample strobe and 12-bit sample
//   o_row/col_control external counter commands {clear, increment, 3'b0}
//   o_row/col_reg_*   row/col shift-register serial data and shift strobe
//   o_row_rst         pixel row reset
//   o_key_wren        conversion start strobe
//   o_ram_wren/data   sample write to RAM
//   o_scan_end        1-cycle pulse at scan completion
//   o_adc_err         sticky conversion timeout flag, cleared by the next scan start
module pixel_scan_ctrl
    import scan_pkg::*;
#(
    parameter int N_ROWS   = 16,
    parameter int N_COLS   = 16,
    parameter int T_RST    = 4,
    parameter int T_INT    = 64,
    parameter int T_SETTLE = 2,
    parameter int T_ADC_TO = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        i_go,
    input  logic        i_adc_valid,
    input  logic [11:0] i_adc_data,
    output logic [4:0]  o_row_control,
    output logic [4:0]  o_col_control,
    output logic        o_row_reg_data,
    output logic        o_row_reg_write,
    output logic        o_col_reg_data,
    output logic        o_col_reg_write,
    output logic        o_row_rst,
    output logic        o_key_wren,
    output logic        o_ram_wren,
    output logic [11:0] o_ram_data,
    output logic        o_scan_end,
    output logic        o_adc_err
);

    // Timers are loaded with T-1 on state entry so the state lasts exactly T cycles
    localparam logic [7:0] RST_LD = 8'(T_RST - 1);
    localparam logic [7:0] INT_LD = 8'(T_INT - 1);
    localparam logic [7:0] SET_LD = 8'(T_SETTLE - 1);
    localparam logic [7:0] ADC_LD = 8'(T_ADC_TO - 1);

    state_t      state, nxt;
    logic [3:0]  row_idx, col_idx, n_row_idx, n_col_idx;
    logic        ld, tz, wr, last_col, last_row;
    logic [7:0]  ld_val;

    scan_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (ld),
        .load_val (ld_val),
        .zero     (tz)
    );

    assign last_col = col_idx == 4'(N_COLS - 1);
    assign last_row = row_idx == 4'(N_ROWS - 1);
    assign wr       = nxt == S_WRITE;

    always_comb begin
        nxt       = state;
        ld        = 1'b0;
        ld_val    = '0;
        n_row_idx = row_idx;
        n_col_idx = col_idx;
        case (state)
            S_IDLE:     nxt = i_go ? S_CLR : S_IDLE;
            S_CLR: begin
                nxt       = S_ROW_SEL;
                n_row_idx = '0;
                n_col_idx = '0;
            end
            S_ROW_SEL: begin
                nxt    = S_ROW_RST;
                ld     = 1'b1;
                ld_val = RST_LD;
            end
            S_ROW_RST: begin
                nxt    = tz ? S_INTEG : S_ROW_RST;
                ld     = tz;
                ld_val = INT_LD;
            end
            S_INTEG:    nxt = tz ? S_COL_SEL : S_INTEG;
            S_COL_SEL: begin
                nxt    = S_SETTLE;
                ld     = 1'b1;
                ld_val = SET_LD;
            end
            S_SETTLE:   nxt = tz ? S_KEY : S_SETTLE;
            S_KEY: begin
                nxt    = S_WAIT_ADC;
                ld     = 1'b1;
                ld_val = ADC_LD;
            end
            S_WAIT_ADC: nxt = (i_adc_valid || tz) ? S_WRITE : S_WAIT_ADC;
            S_WRITE: begin
                nxt       = last_col ? (last_row ? S_DONE : S_ROW_SEL) : S_COL_SEL;
                n_col_idx = last_col ? 4'd0 : col_idx + 4'd1;
                n_row_idx = (last_col && !last_row) ? row_idx + 4'd1 : row_idx;
            end
            S_DONE:     nxt = S_IDLE;
            default:    nxt = S_IDLE;
        endcase
        if (state != S_IDLE && !i_go)
            nxt = S_IDLE;
    end

    // Outputs are registered from the next state so each one is high exactly while in its state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            row_idx         <= '0;
            col_idx         <= '0;
            o_row_control   <= CNT_HOLD;
            o_col_control   <= CNT_HOLD;
            o_row_reg_data  <= 1'b0;
            o_row_reg_write <= 1'b0;
            o_col_reg_data  <= 1'b0;
            o_col_reg_write <= 1'b0;
            o_row_rst       <= 1'b0;
            o_key_wren      <= 1'b0;
            o_ram_wren      <= 1'b0;
            o_ram_data      <= '0;
            o_scan_end      <= 1'b0;
            o_adc_err       <= 1'b0;
        end else if (en) begin
            state           <= nxt;
            row_idx         <= n_row_idx;
            col_idx         <= n_col_idx;
            o_row_control   <= nxt == S_CLR ? CNT_CLR : (wr && last_col && !last_row) ? CNT_INC : CNT_HOLD;
            o_col_control   <= nxt == S_CLR ? CNT_CLR :
                               wr ? (!last_col ? CNT_INC : (last_row ? CNT_HOLD : CNT_CLR)) : CNT_HOLD;
            // Walking one: only the first select after CLR/INTEG carries a 1
            o_row_reg_data  <= nxt == S_ROW_SEL && state == S_CLR;
            o_row_reg_write <= nxt == S_ROW_SEL;
            o_col_reg_data  <= nxt == S_COL_SEL && state == S_INTEG;
            o_col_reg_write <= nxt == S_COL_SEL;
            o_row_rst       <= nxt == S_ROW_RST;
            o_key_wren      <= nxt == S_KEY;
            o_ram_wren      <= wr;
            o_ram_data      <= wr ? (i_adc_valid ? i_adc_data : ADC_TIMEOUT_DATA) : 12'd0;
            o_scan_end      <= nxt == S_DONE;
            o_adc_err       <= nxt == S_CLR ? 1'b0 : (wr && !i_adc_valid) ? 1'b1 : o_adc_err;
        end
    end

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// tb_pixel_scan_ctrl: scoreboard bench for pixel_scan_ctrl at default parameters
module tb_pixel_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, i_go, i_adc_valid;
    logic [11:0] i_adc_data;
    logic [4:0]  o_row_control, o_col_control;
    logic        o_row_reg_data, o_row_reg_write, o_col_reg_data, o_col_reg_write;
    logic        o_row_rst, o_key_wren, o_ram_wren, o_scan_end, o_adc_err;
    logic [11:0] o_ram_data;
    logic [30:0] outs;

    always #5 clk = ~clk;

    pixel_scan_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .i_go            (i_go),
        .i_adc_valid     (i_adc_valid),
        .i_adc_data      (i_adc_data),
        .o_row_control   (o_row_control),
        .o_col_control   (o_col_control),
        .o_row_reg_data  (o_row_reg_data),
        .o_row_reg_write (o_row_reg_write),
        .o_col_reg_data  (o_col_reg_data),
        .o_col_reg_write (o_col_reg_write),
        .o_row_rst       (o_row_rst),
        .o_key_wren      (o_key_wren),
        .o_ram_wren      (o_ram_wren),
        .o_ram_data      (o_ram_data),
        .o_scan_end      (o_scan_end),
        .o_adc_err       (o_adc_err)
    );

    assign outs = {o_row_control, o_col_control, o_row_reg_data, o_row_reg_write, o_col_reg_data,
                   o_col_reg_write, o_row_rst, o_key_wren, o_ram_wren, o_ram_data, o_scan_end, o_adc_err};

    typedef struct {
        logic [11:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, key_cyc = 0, key_cnt = 0, mute = -1;
    int wren_cnt = 0, rowwr_cnt = 0, rowd1_cnt = 0, end_cnt = 0, rst_run = 0;
    logic first_rowd = 1'b0;
    logic skip_run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every RAM write and tracks pulse counts
    always @(negedge clk) begin
        cyc++;
        if (o_key_wren) key_cyc = cyc;
        if (o_row_rst) rst_run++;
        else if (rst_run != 0) begin
            if (!skip_run) chk("row_rst_len", 32'(rst_run), 32'd4);
            rst_run = 0;
        end
        if (o_row_reg_write) begin
            if (rowwr_cnt == 0) first_rowd = o_row_reg_data;
            rowwr_cnt++;
            if (o_row_reg_data) rowd1_cnt++;
        end
        if (o_scan_end) end_cnt++;
        if (o_ram_wren) begin
            wren_cnt++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL ram_write: unexpected write of 0x%0h, none required", o_ram_data);
            end else begin
                chk("ram_data", 32'(o_ram_data), 32'(sb[0].data));
                chk("ram_lat", 32'(cyc - key_cyc), 32'(sb[0].lat));
                void'(sb.pop_front());
            end
        end
    end

    // ADC model: answers 3 cycles after the key strobe with data = row*16+col, except the muted pixel
    initial begin
        i_adc_valid = 1'b0;
        i_adc_data  = '0;
        forever begin
            @(negedge clk);
            if (o_key_wren && !rst) begin
                int idx;
                idx = key_cnt;
                key_cnt++;
                if (idx != mute) begin
                    repeat (3) @(negedge clk);
                    i_adc_valid = 1'b1;
                    i_adc_data  = 12'(idx);
                    @(negedge clk);
                    i_adc_valid = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return o_col_reg_write;
            1:       return o_scan_end;
            2:       return o_key_wren;
            3:       return o_row_rst;
            4:       return !o_row_rst;
            default: return rowwr_cnt >= 2;
        endcase
    endfunction

    task automatic wait_for(input string name, input int w, input int limit);
        int i;
        for (i = 0; i < limit && !sel(w); i++) step();
        chk(name, 32'(sel(w)), 32'd1);
    endtask

    task automatic push_scan(input int n, input int m);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = (i == m) ? 12'hFFF : 12'(i);
            e.lat  = (i == m) ? 256 : 4;
            sb.push_back(e);
        end
    endtask

    task automatic clear_counts();
        wren_cnt  = 0;
        rowwr_cnt = 0;
        rowd1_cnt = 0;
        end_cnt   = 0;
        key_cnt   = 0;
    endtask

    initial begin
        logic [30:0] snap;
        logic changed;
        rst  = 1'b1;
        en   = 1'b1;
        i_go = 1'b0;
        repeat (3) step();
        chk("reset_outputs", 32'(outs), 32'd0);
        rst = 1'b0;
        step();

        // Full default scan with a 10-cycle enable freeze in the first SETTLE
        clear_counts();
        push_scan(256, -1);
        i_go = 1'b1;
        wait_for("col_sel_seen", 0, 500);
        step();
        en = 1'b0;
        snap = outs;
        changed = 1'b0;
        repeat (10) begin
            step();
            if (outs !== snap) changed = 1'b1;
        end
        chk("en_freeze", 32'(changed), 32'd0);
        en = 1'b1;
        step();
        chk("settle_hold", 32'(o_key_wren), 32'd0);
        step();
        chk("settle_resume", 32'(o_key_wren), 32'd1);
        wait_for("scan_end_a", 1, 10000);
        i_go = 1'b0;
        step();
        chk("idle_outs", 32'(outs[30:1]), 32'd0);
        chk("wren_cnt_a", 32'(wren_cnt), 32'd256);
        chk("rowwr_cnt_a", 32'(rowwr_cnt), 32'd16);
        chk("row_data_ones", 32'(rowd1_cnt), 32'd1);
        chk("row_data_first", 32'(first_rowd), 32'd1);
        chk("scan_end_cnt_a", 32'(end_cnt), 32'd1);
        chk("adc_err_a", 32'(o_adc_err), 32'd0);
        chk("sb_empty_a", 32'(sb.size()), 32'd0);

        // ADC silent on row0/col1: timeout writes 0xFFF and sets the sticky error
        clear_counts();
        mute = 1;
        push_scan(256, 1);
        i_go = 1'b1;
        wait_for("scan_end_b", 1, 10000);
        i_go = 1'b0;
        repeat (3) step();
        chk("wren_cnt_b", 32'(wren_cnt), 32'd256);
        chk("scan_end_cnt_b", 32'(end_cnt), 32'd1);
        chk("err_sticky_idle", 32'(o_adc_err), 32'd1);
        chk("sb_empty_b", 32'(sb.size()), 32'd0);

        // Drop go during INTEG of row 1
        clear_counts();
        mute = -1;
        push_scan(16, -1);
        i_go = 1'b1;
        step();
        chk("clr_cmd", 32'(o_row_control), 32'h10);
        chk("err_cleared", 32'(o_adc_err), 32'd0);
        wait_for("row1_sel", 5, 5000);
        wait_for("row1_rst_hi", 3, 50);
        wait_for("row1_rst_lo", 4, 50);
        repeat (5) step();
        i_go = 1'b0;
        step();
        chk("go_drop_outs", 32'(outs), 32'd0);
        repeat (5) step();
        chk("go_drop_no_end", 32'(end_cnt), 32'd0);
        chk("go_drop_wren", 32'(wren_cnt), 32'd16);
        chk("sb_empty_c", 32'(sb.size()), 32'd0);

        // Restart, then async reset mid-WAIT_ADC with valid high
        clear_counts();
        mute = 0;
        i_go = 1'b1;
        step();
        chk("restart_clr", 32'(o_row_control), 32'h10);
        wait_for("key_d", 2, 500);
        repeat (2) step();
        i_adc_valid = 1'b1;
        i_adc_data  = 12'hABC;
        rst  = 1'b1;
        i_go = 1'b0;
        #1;
        chk("rst_wait_outs", 32'(outs), 32'd0);
        step();
        i_adc_valid = 1'b0;
        rst = 1'b0;
        repeat (5) step();
        chk("rst_no_write", 32'(wren_cnt), 32'd0);
        chk("rst_idle_outs", 32'(outs), 32'd0);

        // Async reset takes effect between clock edges
        skip_run = 1'b1;
        i_go = 1'b1;
        wait_for("row_rst_e", 3, 100);
        rst = 1'b1;
        #1;
        chk("async_rst_row_rst", 32'(o_row_rst), 32'd0);
        chk("async_rst_outs", 32'(outs), 32'd0);
        i_go = 1'b0;
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
